shift_rx_ctrl: RTL and testbench
================================

Name: shift_rx_ctrl

Overview:
Frame controller for the serial-in/parallel-out shift path. It detects a frame start and counts exactly NBITS_DATA shifts into an internal shift register (new bit into MSB, LSB-first framing). It then transfers the completed word to an output holding register with a valid/ready handshake. It sits between a serial source and the downstream word consumer, and flags overrun when the consumer stalls.

Parameters:
NBITS_DATA, 4, data bits per frame, and width of the shift register and word_out (must be >= 2).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  reset, asynchronous, active-high.
data_in  input  1  serial data bit, sampled on every rising clk edge while a frame is in progress.
frame_start  input  1  marks the first bit of a frame; only honoured in IDLE.
word_ready  input  1  consumer accepts word_out when word_valid=1.
clear_ovr  input  1  synchronous clear of the overrun flag.
word_out  output  NBITS_DATA  last completed word; bit 0 is the first serial bit.
word_valid  output  1  word_out holds an unconsumed word.
busy  output  1  frame in progress (state != IDLE).
overrun  output  1  sticky flag: a completed word was dropped.
parity_err  output  1  one-cycle pulse on a parity failure; tied to 0 without the macro.

Behaviour:
- Reset (async, immediate): state=IDLE, bit counter=0, shift register=0, word_out=0, word_valid=0, overrun=0, parity_err=0. A partially received frame is discarded.
- Bit counter width: $clog2(NBITS_DATA+1).
- Shift rule on each sampled bit: shreg <= {data_in, shreg[NBITS_DATA-1:1]}.
- IDLE:
  - If frame_start=1 at an edge: sample data_in as bit 0, set count=1, go to SHIFT.
  - Otherwise hold all state.
- SHIFT:
  - Every edge: sample data_in and increment count. frame_start is ignored.
  - At the edge that samples bit NBITS_DATA-1 (count==NBITS_DATA-1 before the edge), perform a word transfer with word_out <= {data_in, shreg[NBITS_DATA-1:1]}. Then count <= 0 and state <= IDLE.
  - Latency: frame_start at edge E0 means word_valid is high after edge E0+NBITS_DATA-1.
  - Back-to-back frames are allowed: a new frame_start is accepted on the edge after the transfer edge.
- Word transfer / handshake:
  - A handshake completes at any edge with word_valid=1 and word_ready=1; word_valid then clears unless a new transfer happens at the same edge.
  - Transfer with word_valid=0, or with a handshake at the same edge: load word_out and set word_valid=1. No overrun.
  - Transfer with word_valid=1 and word_ready=0: drop the new word, keep the old word_out and word_valid, and set overrun=1.
- overrun:
  - Sticky.
  - clear_ovr=1 clears it at the edge.
  - If a new overrun event and clear_ovr coincide, the set wins.
- busy = (state != IDLE), driven combinationally from the state register.
- word_out changes only on a transfer and holds stable while word_valid=1.

Optional Feature:
Macro: SHIFT_RX_PARITY_EN.
- Defined:
  - A frame is NBITS_DATA data bits followed by one even-parity bit. An extra PARITY state follows SHIFT.
  - The edge that samples the last data bit only shifts it in, then goes to PARITY.
  - In PARITY, the next edge samples the parity bit and returns to IDLE.
  - If ^{shreg, data_in} == 0, perform the word transfer with word_out <= shreg.
  - Otherwise drop the word, pulse parity_err=1 for exactly one cycle, and leave word_valid, word_out and overrun untouched.
  - Latency becomes NBITS_DATA edges after the frame_start edge.
- Undefined: no PARITY state, and parity_err is constant 0.

Test Plan:
- Basic frame: frame_start=1 with data_in sequence 1,0,1,1 on four consecutive edges, word_ready=0 → word_out=4'b1101 and word_valid=1 after the 4th edge; busy=1 for 3 cycles, then 0.
- Handshake: word pending, then word_ready=1 for one edge → word_valid=0 next cycle; word_out keeps 4'b1101.
- Overrun: two back-to-back frames 1,0,1,1 and 0,1,1,0 with word_ready=0 → word_out stays 4'b1101 and overrun=1. Then clear_ovr=1 → overrun=0.
- Simultaneous accept and transfer: second frame completes on the same edge that word_ready=1 → word_out=4'b0110, word_valid stays 1, overrun=0.
- Reset mid-frame: assert reset after 2 bits → all outputs 0 immediately. A following frame 0,0,0,1 yields word_out=4'b1000 with no residue.
- With SHIFT_RX_PARITY_EN: frame 1,0,1,1 with parity 1 → word_out=4'b1101 and valid after 5 edges. Same frame with parity 0 → parity_err pulses once, word_valid=0.

Source files
------------

// File: rtl/shift_rx_ctrl.sv
// shift_rx_ctrl: frame controller for a serial-in/parallel-out shift path.
// Detects a frame start, shifts NBITS_DATA bits LSB-first into a shift register,
// then hands the finished word to a holding register with a valid/ready handshake.
// A finished word that arrives while the holding register is still full is dropped,
// and the sticky overrun flag is set.
// Optional feature macro: SHIFT_RX_PARITY_EN adds a trailing even-parity bit per frame.

module shift_rx_ctrl #(
    parameter int unsigned NBITS_DATA = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_in,
    input  logic                  frame_start,
    input  logic                  word_ready,
    input  logic                  clear_ovr,
    output logic [NBITS_DATA-1:0] word_out,
    output logic                  word_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic                  parity_err
);

    localparam int unsigned CntW = $clog2(NBITS_DATA + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(NBITS_DATA - 1);

`ifdef SHIFT_RX_PARITY_EN
    typedef enum logic [1:0] {StIdle = 2'd0, StShift = 2'd1, StParity = 2'd2} state_e;
`else
    typedef enum logic [1:0] {StIdle = 2'd0, StShift = 2'd1} state_e;
`endif

    state_e                  state_q, state_d;
    logic [CntW-1:0]         count_q, count_d;
    logic [NBITS_DATA-1:0]   shreg_q, shreg_d;
    logic [NBITS_DATA-1:0]   word_q, word_d;
    logic                    valid_q, valid_d;
    logic                    ovr_q, ovr_d;
    logic [NBITS_DATA-1:0]   shifted;
    logic [NBITS_DATA-1:0]   xfer_word;
    logic                    xfer;
    logic                    handshake;

`ifdef SHIFT_RX_PARITY_EN
    logic                    perr_q, perr_d;
`else
    // The LSB only feeds the parity path; without it the bit falls off the end.
    logic                    unused_shreg_lsb;
    assign unused_shreg_lsb = shreg_q[0];
`endif

    // New bit enters at the MSB so that after a full frame bit 0 is the first bit.
    assign shifted = {data_in, shreg_q[NBITS_DATA-1:1]};

    // State register and all datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            shreg_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SHIFT_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shreg_q <= shreg_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
`ifdef SHIFT_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    // Next-state logic: frame sequencing, bit counting and transfer request.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shreg_d   = shreg_q;
        xfer      = 1'b0;
        xfer_word = shifted;
`ifdef SHIFT_RX_PARITY_EN
        perr_d    = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (frame_start) begin
                    shreg_d = shifted;
                    count_d = CntW'(1);
                    state_d = StShift;
                end
            end
            StShift: begin
                shreg_d = shifted;
                if (count_q == LastCnt) begin
`ifdef SHIFT_RX_PARITY_EN
                    count_d = count_q + CntW'(1);
                    state_d = StParity;
`else
                    xfer      = 1'b1;
                    xfer_word = shifted;
                    count_d   = '0;
                    state_d   = StIdle;
`endif
                end else begin
                    count_d = count_q + CntW'(1);
                end
            end
`ifdef SHIFT_RX_PARITY_EN
            StParity: begin
                // Parity bit is checked but never shifted in.
                count_d = '0;
                state_d = StIdle;
                if (^{shreg_q, data_in} == 1'b0) begin
                    xfer      = 1'b1;
                    xfer_word = shreg_q;
                end else begin
                    perr_d = 1'b1;
                end
            end
`endif
            default: begin
                count_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Holding register handshake and sticky overrun; a new overrun beats clear_ovr.
    always_comb begin
        handshake = valid_q & word_ready;
        word_d    = word_q;
        valid_d   = valid_q;
        ovr_d     = clear_ovr ? 1'b0 : ovr_q;
        if (xfer) begin
            if (!valid_q || handshake) begin
                word_d  = xfer_word;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (handshake) begin
            valid_d = 1'b0;
        end
    end

    // Outputs straight from registers.
    always_comb begin
        busy       = (state_q != StIdle);
        word_out   = word_q;
        word_valid = valid_q;
        overrun    = ovr_q;
`ifdef SHIFT_RX_PARITY_EN
        parity_err = perr_q;
`else
        parity_err = 1'b0;
`endif
    end

endmodule

// File: tb/tb_shift_rx_ctrl.sv
// Testbench for shift_rx_ctrl: directed vector table, a mid-frame reset sequence,
// then randomized traffic checked against a frame-level reference model.
// Honours SHIFT_RX_PARITY_EN the same way as the design.

module tb_shift_rx_ctrl;

    localparam int N = 4;
`ifdef SHIFT_RX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
    localparam int FRAME_LEN = N + 1;
`else
    localparam bit PARITY_EN = 1'b0;
    localparam int FRAME_LEN = N;
`endif

    logic         clk;
    logic         reset;
    logic         data_in;
    logic         frame_start;
    logic         word_ready;
    logic         clear_ovr;
    logic [N-1:0] word_out;
    logic         word_valid;
    logic         busy;
    logic         overrun;
    logic         parity_err;

    shift_rx_ctrl #(.NBITS_DATA(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .frame_start(frame_start),
        .word_ready (word_ready),
        .clear_ovr  (clear_ovr),
        .word_out   (word_out),
        .word_valid (word_valid),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: collects the bits of a frame and acts once the frame is whole.
    bit           m_busy;
    bit           m_valid;
    bit           m_ovr;
    bit           m_perr;
    logic [N-1:0] m_word;
    bit           m_bits[$];

    typedef struct {
        bit           fs;
        bit           din;
        bit           rdy;
        bit           clr;
        logic [N-1:0] word;
        bit           valid;
        bit           busy;
        bit           ovr;
        bit           perr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit fs, bit din, bit rdy, bit clr, logic [N-1:0] word,
                                bit valid, bit bsy, bit ovr, bit perr);
        vec_t v;
        v.fs = fs; v.din = din; v.rdy = rdy; v.clr = clr;
        v.word = word; v.valid = valid; v.busy = bsy; v.ovr = ovr; v.perr = perr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_busy = 0; m_valid = 0; m_ovr = 0; m_perr = 0; m_word = '0;
        m_bits.delete();
    endtask

    task automatic model_step(input bit fs, input bit din, input bit rdy, input bit clr);
        bit           hs;
        bit           xfer;
        bit           ovr_set;
        bit           par;
        logic [N-1:0] w;
        hs = m_valid && rdy;
        xfer = 0;
        ovr_set = 0;
        w = '0;
        m_perr = 0;
        if (!m_busy) begin
            if (fs) begin
                m_bits.delete();
                m_bits.push_back(din);
                m_busy = 1;
            end
        end else begin
            m_bits.push_back(din);
            if (m_bits.size() == FRAME_LEN) begin
                m_busy = 0;
                par = 0;
                for (int i = 0; i < FRAME_LEN; i++) par ^= m_bits[i];
                for (int i = 0; i < N; i++) w[i] = m_bits[i];
                if (PARITY_EN && par) m_perr = 1;
                else xfer = 1;
            end
        end
        if (xfer) begin
            if (!m_valid || hs) begin
                m_word = w;
                m_valid = 1;
            end else begin
                ovr_set = 1;
            end
        end else if (hs) begin
            m_valid = 0;
        end
        m_ovr = ovr_set ? 1'b1 : (clr ? 1'b0 : m_ovr);
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic tick(input bit fs, input bit din, input bit rdy, input bit clr);
        frame_start = fs; data_in = din; word_ready = rdy; clear_ovr = clr;
        model_step(fs, din, rdy, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("async_reset", {27'd0, word_out, word_valid, busy, overrun, parity_err}, 32'd0);
        #1 reset = 1'b0;
    endtask

    localparam logic [N-1:0] W1101 = 4'b1101;
    localparam logic [N-1:0] W0110 = 4'b0110;
    localparam logic [N-1:0] W1000 = 4'b1000;

    initial begin
        bit           frm[$];
        logic [N-1:0] zero_w;
        zero_w = '0;
        reset = 1'b0; data_in = 0; frame_start = 0; word_ready = 0; clear_ovr = 0;
        model_reset();
        #1 reset = 1'b1;
        #1;
        check("reset_state", {27'd0, word_out, word_valid, busy, overrun, parity_err}, 32'd0);
        #6 reset = 1'b0;

`ifdef SHIFT_RX_PARITY_EN
        tbl.push_back(mk(1, 1, 0, 0, zero_w, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, zero_w, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, zero_w, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, zero_w, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, W1101,  1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, W1101,  0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, W1101,  0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, W1101,  0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, W1101,  0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, W1101,  0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, W1101,  0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, W1101,  0, 0, 0, 0));
`else
        tbl.push_back(mk(1, 1, 0, 0, zero_w, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, zero_w, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, zero_w, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, W1101,  1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, W1101,  0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, W1101,  0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, W1101,  0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, W1101,  0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, W1101,  1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, W1101,  1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, W1101,  1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, W1101,  1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, W1101,  1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, W1101,  1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, W1101,  1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, W1101,  1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, W1101,  1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, W0110,  1, 0, 0, 0));
`endif

        foreach (tbl[i]) begin
            tick(tbl[i].fs, tbl[i].din, tbl[i].rdy, tbl[i].clr);
            check($sformatf("vec%0d_word", i), {28'd0, word_out}, {28'd0, tbl[i].word});
            check($sformatf("vec%0d_valid", i), {31'd0, word_valid}, {31'd0, tbl[i].valid});
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
            check($sformatf("vec%0d_ovr", i), {31'd0, overrun}, {31'd0, tbl[i].ovr});
            check($sformatf("vec%0d_perr", i), {31'd0, parity_err}, {31'd0, tbl[i].perr});
        end

        // Reset two bits into a frame, then a clean frame must carry no residue.
        tick(1, 1, 0, 0);
        tick(0, 1, 0, 0);
        check("midframe_busy", {31'd0, busy}, 32'd1);
        pulse_reset();
        frm = '{0, 0, 0, 1};
        if (PARITY_EN) frm.push_back(1);
        foreach (frm[i]) tick(i == 0, frm[i], 0, 0);
        check("post_reset_word", {28'd0, word_out}, {28'd0, W1000});
        check("post_reset_valid", {31'd0, word_valid}, 32'd1);
        check("post_reset_busy", {31'd0, busy}, 32'd0);

        // Randomized traffic against the model, with occasional async resets.
        for (int c = 0; c < 3000; c++) begin
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
            check($sformatf("rand%0d", c),
                  {27'd0, word_out, word_valid, busy, overrun, parity_err},
                  {27'd0, m_word, m_valid, m_busy, m_ovr, m_perr});
            if ($urandom_range(0, 199) == 0) pulse_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
